// File: rtl/lvds_rx_pkg.sv
// Shared types and constants for the LVDS 7:1 receive training path.
// The rotation helper tells whether a word is some rotation of the training pattern.
package lvds_rx_pkg;

    localparam int NUM_PHASE = 8;
    localparam int PH_W      = 3;
    localparam int WORD_W    = 7;
    localparam int SLIP_MAX  = 7;
    localparam int EVAL_CYC  = 16;

    localparam logic [WORD_W-1:0] DEF_PATTERN = 7'b1100011;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SWEEP_SETTLE,
        ST_SWEEP_CHECK,
        ST_EVAL,
        ST_APPLY_SETTLE,
        ST_SLIP_CHECK,
        ST_SLIP_SETTLE,
        ST_LOCKED,
        ST_FAIL
    } train_state_e;

    // A sampling phase is good if the clock lane shows the pattern at any bit offset;
    // word alignment is fixed later with bitslips.
    function automatic logic is_rotation(input logic [WORD_W-1:0] word,
                                         input logic [WORD_W-1:0] pat);
        logic [2*WORD_W-1:0] dbl;
        logic                hit;
        dbl = {pat, pat};
        hit = 1'b0;
        for (int k = 0; k < WORD_W; k++) begin
            if (dbl[(WORD_W - k) +: WORD_W] == word) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/lvds_win_eval.sv
// Sequential circular-run finder over the 8-entry phase pass map.
// A go pulse starts a 16-step scan; results are valid in the cycle done is high.
module lvds_win_eval
    import lvds_rx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [NUM_PHASE-1:0] phase_flag,
    output logic [PH_W-1:0]      win_start,
    output logic [3:0]           win_len,
    output logic [PH_W-1:0]      win_centre,
    output logic                 done
);

    logic [3:0]      idx_q, idx_d;
    logic            active_q, active_d;
    logic [PH_W-1:0] cur_start_q, cur_start_d;
    logic [3:0]      cur_len_q, cur_len_d;
    logic            cur_ok_q, cur_ok_d;
    logic [PH_W-1:0] best_start_q, best_start_d;
    logic [3:0]      best_len_q, best_len_d;
    logic [3:0]      half_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            active_q     <= 1'b0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            cur_ok_q     <= 1'b0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            idx_q        <= idx_d;
            active_q     <= active_d;
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            cur_ok_q     <= cur_ok_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    // Scanning indices 0..15 lets a window that wraps past phase 7 be seen as one run;
    // runs that only begin in the second lap are duplicates and are not counted.
    always_comb begin
        idx_d        = idx_q;
        active_d     = active_q;
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        cur_ok_d     = cur_ok_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        if (go) begin
            idx_d        = '0;
            active_d     = 1'b1;
            cur_start_d  = '0;
            cur_len_d    = '0;
            cur_ok_d     = 1'b0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (active_q) begin
            if (phase_flag[idx_q[PH_W-1:0]]) begin
                if (cur_len_q == 4'd0) begin
                    cur_start_d = idx_q[PH_W-1:0];
                    cur_len_d   = 4'd1;
                    cur_ok_d    = ~idx_q[3];
                end else if (cur_len_q < 4'(NUM_PHASE)) begin
                    cur_len_d = cur_len_q + 4'd1;
                end
            end else begin
                cur_len_d = 4'd0;
            end
            // Strictly longer only, so ties keep the earliest start.
            if (cur_ok_d && (cur_len_d > best_len_q)) begin
                best_len_d   = cur_len_d;
                best_start_d = cur_start_d;
            end
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'(EVAL_CYC - 1)) active_d = 1'b0;
        end
    end

    always_comb begin
        half_len   = (best_len_d - 4'd1) >> 1;
        win_start  = best_start_d;
        win_len    = best_len_d;
        win_centre = best_start_d + half_len[PH_W-1:0];
        done       = active_q && (idx_q == 4'(EVAL_CYC - 1));
    end

endmodule

// File: rtl/lvds_phase_train_ctl.sv
// LVDS 7:1 receive training: phase sweep, centre-of-window selection,
// bitslip word alignment and lock monitoring, all in rx_sclk.
module lvds_phase_train_ctl
    import lvds_rx_pkg::*;
#(
    parameter logic [WORD_W-1:0] PATTERN    = DEF_PATTERN,
    parameter int                SETTLE_CYC = 16,
    parameter int                CHECK_CYC  = 64,
    parameter int                LOSS_THR   = 4
) (
    input  logic                 rx_sclk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD_W-1:0]    rx_data,
    output logic [PH_W-1:0]      phase_sel,
    output logic                 phase_load,
    output logic                 bitslip,
    output logic [NUM_PHASE-1:0] phase_flag,
    output logic [PH_W-1:0]      best_phase,
    output logic [3:0]           win_len,
    output logic                 busy,
    output logic                 aligned,
    output logic                 train_fail
);

    localparam int CNT_MAX = (SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int LOSS_W  = $clog2(LOSS_THR + 1);

    train_state_e         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PH_W-1:0]      phase_sel_q, phase_sel_d;
    logic                 phase_load_q, phase_load_d;
    logic                 bitslip_q, bitslip_d;
    logic [NUM_PHASE-1:0] phase_flag_q, phase_flag_d;
    logic [PH_W-1:0]      best_phase_q, best_phase_d;
    logic [3:0]           win_len_q, win_len_d;
    logic [2:0]           slip_cnt_q, slip_cnt_d;
    logic [LOSS_W-1:0]    loss_cnt_q, loss_cnt_d;

    logic            word_is_rot, word_exact;
    logic            settle_done, check_done, phase_done, last_phase;
    logic            loss_hit, restart, eval_go;
    logic [PH_W-1:0] ev_start, ev_centre;
    logic [3:0]      ev_len;
    logic            ev_done;

    always_comb begin
        word_is_rot = is_rotation(rx_data, PATTERN);
        word_exact  = (rx_data == PATTERN);
        settle_done = (cnt_q == CNT_W'(SETTLE_CYC));
        check_done  = (cnt_q == CNT_W'(CHECK_CYC - 1));
        phase_done  = !word_is_rot || check_done;
        last_phase  = (phase_sel_q == PH_W'(NUM_PHASE - 1));
        loss_hit    = (state_q == ST_LOCKED) && !word_exact
                      && (loss_cnt_q == LOSS_W'(LOSS_THR - 1));
        // Lock loss and start share one restart path, so a coincidence yields one load.
        restart     = start || loss_hit;
        eval_go     = !restart && (state_q == ST_SWEEP_CHECK) && phase_done && last_phase;
    end

    lvds_win_eval u_win_eval (
        .clk        (rx_sclk),
        .rst        (rst),
        .go         (eval_go),
        .phase_flag (phase_flag_q),
        .win_start  (ev_start),
        .win_len    (ev_len),
        .win_centre (ev_centre),
        .done       (ev_done)
    );

    always_ff @(posedge rx_sclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            phase_sel_q  <= '0;
            phase_load_q <= 1'b0;
            bitslip_q    <= 1'b0;
            phase_flag_q <= '0;
            best_phase_q <= '0;
            win_len_q    <= '0;
            slip_cnt_q   <= '0;
            loss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phase_sel_q  <= phase_sel_d;
            phase_load_q <= phase_load_d;
            bitslip_q    <= bitslip_d;
            phase_flag_q <= phase_flag_d;
            best_phase_q <= best_phase_d;
            win_len_q    <= win_len_d;
            slip_cnt_q   <= slip_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = ST_SWEEP_SETTLE;
        end else begin
            case (state_q)
                ST_SWEEP_SETTLE: if (settle_done) state_d = ST_SWEEP_CHECK;
                ST_SWEEP_CHECK:  if (phase_done) state_d = last_phase ? ST_EVAL : ST_SWEEP_SETTLE;
                ST_EVAL:         if (ev_done) state_d = (ev_len == 4'd0) ? ST_FAIL : ST_APPLY_SETTLE;
                ST_APPLY_SETTLE,
                ST_SLIP_SETTLE:  if (settle_done) state_d = ST_SLIP_CHECK;
                ST_SLIP_CHECK: begin
                    if (word_exact)                        state_d = ST_LOCKED;
                    else if (slip_cnt_q < 3'(SLIP_MAX))    state_d = ST_SLIP_SETTLE;
                    else                                   state_d = ST_FAIL;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        phase_sel_d  = phase_sel_q;
        phase_load_d = 1'b0;
        bitslip_d    = 1'b0;
        phase_flag_d = phase_flag_q;
        best_phase_d = best_phase_q;
        win_len_d    = win_len_q;
        slip_cnt_d   = slip_cnt_q;
        loss_cnt_d   = loss_cnt_q;
        if (restart) begin
            cnt_d        = '0;
            phase_sel_d  = '0;
            phase_load_d = 1'b1;
            phase_flag_d = '0;
            slip_cnt_d   = '0;
            loss_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_SWEEP_SETTLE, ST_APPLY_SETTLE, ST_SLIP_SETTLE: begin
                    cnt_d = settle_done ? '0 : cnt_q + CNT_W'(1);
                end
                ST_SWEEP_CHECK: begin
                    if (phase_done) begin
                        phase_flag_d[phase_sel_q] = word_is_rot;
                        cnt_d = '0;
                        if (!last_phase) begin
                            phase_sel_d  = phase_sel_q + PH_W'(1);
                            phase_load_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_EVAL: begin
                    // On an empty map best_phase/win_len keep the previous training's values.
                    if (ev_done && (ev_len != 4'd0)) begin
                        best_phase_d = ev_centre;
                        win_len_d    = ev_len;
                        phase_sel_d  = ev_centre;
                        phase_load_d = 1'b1;
                        cnt_d        = '0;
                        slip_cnt_d   = '0;
                    end
                end
                ST_SLIP_CHECK: begin
                    if (word_exact) begin
                        loss_cnt_d = '0;
                    end else if (slip_cnt_q < 3'(SLIP_MAX)) begin
                        bitslip_d  = 1'b1;
                        slip_cnt_d = slip_cnt_q + 3'd1;
                        cnt_d      = '0;
                    end
                end
                ST_LOCKED: loss_cnt_d = word_exact ? '0 : loss_cnt_q + LOSS_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        busy       = !((state_q == ST_IDLE) || (state_q == ST_LOCKED) || (state_q == ST_FAIL));
        aligned    = (state_q == ST_LOCKED);
        train_fail = (state_q == ST_FAIL);
        phase_sel  = phase_sel_q;
        phase_load = phase_load_q;
        bitslip    = bitslip_q;
        phase_flag = phase_flag_q;
        best_phase = best_phase_q;
        win_len    = win_len_q;
    end

    a_centre: assert property (@(posedge rx_sclk) disable iff (rst)
        (ev_done && (ev_len != 4'd0)) |->
            (ev_centre == PH_W'(ev_start + PH_W'((ev_len - 4'd1) >> 1))));

endmodule

// File: tb/tb_lvds_phase_train_ctl.sv
// Randomized bench: a behavioural receiver model drives rx_data, a scoreboard
// predicts each training outcome and a monitor checks it when busy falls.
module tb_lvds_phase_train_ctl;

    localparam int          S   = 16;
    localparam int          C   = 64;
    localparam int          L   = 4;
    localparam logic [6:0]  PAT = 7'b1100011;

    logic       rx_sclk = 1'b0;
    logic       rst     = 1'b1;
    logic       start   = 1'b0;
    logic [6:0] rx_data = '0;
    logic [2:0] phase_sel, best_phase;
    logic       phase_load, bitslip, busy, aligned, train_fail;
    logic [7:0] phase_flag;
    logic [3:0] win_len;

    lvds_phase_train_ctl #(.PATTERN(PAT), .SETTLE_CYC(S), .CHECK_CYC(C), .LOSS_THR(L)) dut (
        .rx_sclk    (rx_sclk),
        .rst        (rst),
        .start      (start),
        .rx_data    (rx_data),
        .phase_sel  (phase_sel),
        .phase_load (phase_load),
        .bitslip    (bitslip),
        .phase_flag (phase_flag),
        .best_phase (best_phase),
        .win_len    (win_len),
        .busy       (busy),
        .aligned    (aligned),
        .train_fail (train_fail)
    );

    always #5 rx_sclk = ~rx_sclk;

    typedef struct {
        int flag; int len; int best; int aligned; int fail; int slips; int lat; int t0;
    } exp_t;

    exp_t       sb[$];
    int         n_pass = 0, n_tot = 0, cyc = 0, overlap = 0, t_last = 0;
    logic [7:0] good_map = '0;
    int         rot_r = 0;
    bit         slip_ok = 1'b1, ovr_en = 1'b0;
    logic [6:0] ovr_word = '0;
    int         last_best = 0, last_len = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_tot++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    endtask

    function automatic logic [6:0] rotl(input logic [6:0] w, input int k);
        int v;
        v = (int'(w) << k) | (int'(w) >> (7 - k));
        return 7'(v & 127);
    endfunction

    function automatic bit is_rot(input logic [6:0] w);
        for (int k = 0; k < 7; k++) if (rotl(PAT, k) == w) return 1'b1;
        return 1'b0;
    endfunction

    // Widest circular run of passing phases; earliest start wins ties.
    function automatic void win_model(input logic [7:0] m, output int bs, output int bl);
        bs = 0; bl = 0;
        for (int s = 0; s < 8; s++) begin
            int l = 0;
            while (l < 8 && m[(s + l) % 8]) l++;
            if (l > bl) begin bl = l; bs = s; end
        end
    endfunction

    task automatic push_exp(input int t0);
        exp_t e; int ws, wl, sweep;
        win_model(good_map, ws, wl);
        sweep = 0;
        for (int p = 0; p < 8; p++) sweep += good_map[p] ? (1 + S + C) : (S + 2);
        e.t0 = t0; e.flag = int'(good_map);
        if (wl == 0) begin
            e.slips = 0; e.aligned = 0; e.fail = 1; e.lat = 1 + sweep + 16;
        end else begin
            e.slips   = slip_ok ? rot_r : 7;
            e.aligned = slip_ok ? 1 : 0;
            e.fail    = slip_ok ? 0 : 1;
            e.lat     = 1 + sweep + 16 + (S + 2) * (e.slips + 1);
            last_len  = wl;
            last_best = (ws + (wl - 1) / 2) % 8;
        end
        e.len = last_len; e.best = last_best;
        sb.push_back(e);
    endtask

    initial forever begin @(posedge rx_sclk); cyc++; end

    // Receiver model: good phases show the pattern rotated by rot_r, each bitslip
    // rotates it one step back; bad phases show random non-pattern words.
    initial forever begin
        logic [6:0] w;
        @(negedge rx_sclk); #1;
        if (bitslip && slip_ok) rot_r = (rot_r + 6) % 7;
        if (ovr_en) rx_data = ovr_word;
        else if (good_map[phase_sel]) rx_data = rotl(PAT, rot_r);
        else begin
            w = 7'($urandom);
            while (is_rot(w)) w = 7'($urandom);
            rx_data = w;
        end
    end

    initial begin
        exp_t e; bit pb; int slips, last_slip;
        pb = 1'b0; slips = 0; last_slip = -1;
        forever begin
            @(negedge rx_sclk);
            if (phase_load && bitslip) overlap++;
            if (busy && !pb) begin slips = 0; last_slip = -1; end
            if (bitslip) begin
                if (last_slip >= 0) chk("slip_spacing", cyc - last_slip - 1, S + 1);
                last_slip = cyc; slips++;
            end
            if (!busy && pb && sb.size() > 0) begin
                e = sb.pop_front();
                chk("phase_flag", int'(phase_flag), e.flag);
                chk("win_len", int'(win_len), e.len);
                chk("best_phase", int'(best_phase), e.best);
                chk("aligned", int'(aligned), e.aligned);
                chk("train_fail", int'(train_fail), e.fail);
                chk("bitslips", slips, e.slips);
                chk("latency", cyc - e.t0, e.lat);
            end
            pb = busy;
        end
    end

    task automatic pulse_start(input bit push);
        @(negedge rx_sclk);
        start = 1'b1; t_last = cyc;
        if (push) push_exp(cyc);
        @(negedge rx_sclk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy && k < 4000) begin @(negedge rx_sclk); k++; end
        chk(nm, int'(busy), 0);
        @(negedge rx_sclk);
    endtask

    task automatic train(input logic [7:0] m, input int rot, input bit sok);
        good_map = m; rot_r = rot; slip_ok = sok;
        pulse_start(1'b1);
        wait_idle("train_done");
    endtask

    function automatic int all_outs();
        return int'({phase_sel, phase_load, bitslip, phase_flag, best_phase, win_len,
                     busy, aligned, train_fail});
    endfunction

    initial begin
        int k, nl;
        repeat (3) @(negedge rx_sclk);
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        @(negedge rx_sclk);
        chk("idle_after_reset", all_outs(), 0);

        train(8'hFF, 0, 1'b1);

        // Lock monitoring: three misses hold lock, four drop it and restart.
        for (int i = 0; i < 3; i++) begin @(negedge rx_sclk); ovr_word = 7'h00; ovr_en = 1'b1; end
        @(negedge rx_sclk); ovr_en = 1'b0;
        chk("lock_hold_3miss", int'(aligned), 1);
        repeat (4) @(negedge rx_sclk);
        chk("lock_hold_later", int'(aligned), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge rx_sclk); ovr_en = 1'b1;
            if (i == 3) begin chk("lock_before_thr", int'(aligned), 1); push_exp(cyc); end
        end
        @(negedge rx_sclk); ovr_en = 1'b0;
        chk("loss_aligned_low", int'(aligned), 0);
        chk("loss_phase_load", int'(phase_load), 1);
        chk("loss_phase_sel", int'(phase_sel), 0);
        wait_idle("loss_retrain_done");

        train(8'hC3, 0, 1'b1);
        train(8'hFF, 3, 1'b1);
        train(8'h3C, 2, 1'b0);
        train(8'h00, 0, 1'b1);
        chk("nopass_busy", int'(busy), 0);
        train(8'h18, 1, 1'b1);

        // start arriving together with the lock-loss threshold
        for (int i = 0; i < 4; i++) begin
            @(negedge rx_sclk); ovr_word = 7'h00; ovr_en = 1'b1;
            if (i == 3) begin start = 1'b1; push_exp(cyc); end
        end
        @(negedge rx_sclk); start = 1'b0; ovr_en = 1'b0;
        chk("coinc_load", int'(phase_load), 1);
        nl = 0;
        repeat (6) begin @(negedge rx_sclk); nl += int'(phase_load); end
        chk("coinc_single_load", nl, 0);
        wait_idle("coinc_done");

        // start mid-sweep at phase 5
        good_map = 8'hFF; rot_r = 0; slip_ok = 1'b1;
        pulse_start(1'b0);
        k = 0;
        while (phase_sel != 3'd5 && k < 2000) begin @(negedge rx_sclk); k++; end
        chk("reach_phase5", int'(phase_sel), 5);
        start = 1'b1; push_exp(cyc);
        @(negedge rx_sclk); start = 1'b0;
        chk("abort_phase_sel", int'(phase_sel), 0);
        chk("abort_flag_clear", int'(phase_flag), 0);
        chk("abort_phase_load", int'(phase_load), 1);
        wait_idle("abort_done");

        for (int i = 0; i < 6; i++)
            train(8'($urandom), int'($urandom_range(0, 6)), ($urandom_range(0, 5) != 0));

        // reset pulse in the middle of EVAL
        good_map = 8'hFF; rot_r = 0; slip_ok = 1'b1;
        pulse_start(1'b0);
        k = 0;
        while (cyc < t_last + 655 && k < 2000) begin @(negedge rx_sclk); k++; end
        chk("mid_eval_busy", int'(busy), 1);
        rst = 1'b1; #1;
        chk("rst_async_clear", all_outs(), 0);
        @(negedge rx_sclk); rst = 1'b0; #1;
        chk("rst_release_quiet", all_outs(), 0);
        @(negedge rx_sclk);
        chk("rst_no_pulse", int'({phase_load, bitslip, busy}), 0);
        last_best = 0; last_len = 0;
        train(8'h0E, 4, 1'b1);

        chk("no_load_slip_overlap", overlap, 0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_tot);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lvds_phase_train_ctl.md
# lvds_phase_train_ctl

Training controller for the LVDS 7:1 receive path, clocked by `rx_sclk`. It sweeps all eight sampling phases of the receiver and checks the deserialized clock-lane word at each one. The resulting per-phase pass map is published as `phase_flag[7:0]`, which is the signal set the team probes on the debug core. The controller then selects the centre of the widest passing window, word-aligns with bitslips, and monitors lock afterwards.

## Interface
- `PATTERN`, 7'b1100011, expected clock-lane word once aligned.
- `SETTLE_CYC`, 16, wait cycles after every `phase_load` or `bitslip` before sampling (≥1).
- `CHECK_CYC`, 64, consecutive matching cycles required for a phase to pass (≥1).
- `LOSS_THR`, 4, consecutive mismatches in LOCKED that drop lock (≥1).
- `rx_sclk`  in  1  receiver parallel clock; sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse; begins or restarts training.
- `rx_data`  in  7  deserialized clock-lane word.
- `phase_sel`  out  3  phase select to the receiver.
- `phase_load`  out  1  one-cycle strobe, asserted in the cycle `phase_sel` changes.
- `bitslip`  out  1  one-cycle bitslip request.
- `phase_flag`  out  8  per-phase pass map from the last sweep.
- `best_phase`  out  3  selected centre phase.
- `win_len`  out  4  length of the widest window (0..8).
- `busy`  out  1  high in every state except IDLE, LOCKED and FAIL.
- `aligned`  out  1  high only in LOCKED.
- `train_fail`  out  1  high only in FAIL.

## Operation
- **States:** IDLE, SWEEP_SETTLE, SWEEP_CHECK, EVAL, APPLY_SETTLE, SLIP_CHECK, SLIP_SETTLE, LOCKED, FAIL.
- **Start from IDLE, LOCKED or FAIL:** on `start`:
  - clear `phase_flag`;
  - set `phase_sel`=0 and pulse `phase_load`;
  - go to SWEEP_SETTLE.
- **Start while `busy`:** `start` aborts the current training and restarts it identically.
- **SWEEP_SETTLE:** count `SETTLE_CYC` cycles, then go to SWEEP_CHECK.
- **SWEEP_CHECK:**
  - A phase passes if `rx_data` equals any of the 7 rotations of `PATTERN` on `CHECK_CYC` consecutive cycles.
  - The first mismatch fails the phase immediately.
  - Write the result to `phase_flag[phase_sel]`.
  - If `phase_sel`<7: increment `phase_sel`, pulse `phase_load`, go to SWEEP_SETTLE.
  - Otherwise go to EVAL.
- **EVAL:** a fixed 16 cycles; cycle i examines `phase_flag[i mod 8]`, so windows that wrap past phase 7 are found as one run.
  - Only runs starting at i<8 are counted.
  - Run length is capped at 8.
  - Ties go to the earliest start.
  - centre = (start + (len−1)/2) mod 8, with integer division.
  - If len=0: go to FAIL.
  - Otherwise: set `best_phase` and `win_len`, drive `phase_sel`=centre, pulse `phase_load`, go to APPLY_SETTLE.
- **APPLY_SETTLE / SLIP_SETTLE:** count `SETTLE_CYC` cycles, then go to SLIP_CHECK.
- **SLIP_CHECK:**
  - `rx_data`==`PATTERN` exactly: go to LOCKED.
  - Otherwise, if fewer than 7 slips have been issued: pulse `bitslip`, increment the slip count, go to SLIP_SETTLE.
  - Otherwise (7 slips already issued): go to FAIL.
- **LOCKED:**
  - Count consecutive cycles with `rx_data`≠`PATTERN`; any match clears the count.
  - At `LOSS_THR`: drop `aligned` and restart training exactly as on `start`.
- **FAIL:** hold until `start`.

## Timing
- **Reset values:** all outputs 0; state IDLE; all counters 0.
- **`phase_load` and `bitslip`:** registered, one-cycle pulses; never asserted in the same cycle.
- **Sweep of one passing phase:** 1 + `SETTLE_CYC` + `CHECK_CYC` cycles. With defaults, a full all-pass sweep takes 8 × 81 = 648 cycles.
- **EVAL:** exactly 16 cycles. `best_phase` and `win_len` update in the cycle EVAL exits; they hold their previous values when EVAL exits to FAIL.
- **`aligned`:** asserted in the cycle after the matching SLIP_CHECK sample; deasserted in the cycle after the `LOSS_THR`-th mismatch.
- **`start` coinciding with a `LOSS_THR` event:** single restart; no double `phase_load`.
- **`rst` mid-operation:** all state cleared immediately; no pulse may be emitted in the first cycle after release.

## Structure
- Shared package `lvds_rx_pkg`:
  - state enum;
  - default `PATTERN`;
  - `NUM_PHASE`=8;
  - phase width 3;
  - slip limit 7.
- One sub-module `lvds_win_eval`: the sequential circular-run finder. Inputs: `phase_flag`, a go pulse. Outputs: start, len, centre, done.
- All other logic lives in the top-level FSM.

## Test plan
- **All 8 phases pass, word already aligned:**
  - `phase_flag`=8'hFF, `win_len`=8, `best_phase`=3;
  - zero bitslips;
  - `aligned` rises 1 + 648 + 16 + 1 + 16 + 1 cycles after `start` (defaults).
- **Phases 6,7,0,1 pass:** `phase_flag`=8'hC3, `win_len`=4, `best_phase`=7 (wrap-around window).
- **No phase passes:** `phase_flag`=0, `train_fail`=1, `aligned`=0, `busy`=0; a second `start` retrains.
- **Correct phase, word rotated by 3:** exactly 3 `bitslip` pulses, each separated by `SETTLE_CYC`+1 cycles, then `aligned`=1. A word that never aligns gives 7 slips then `train_fail`.
- **In LOCKED:**
  - 3 mismatches then a match: lock held;
  - 4 consecutive mismatches: `aligned` drops, `phase_load` pulses with `phase_sel`=0.
- **Misuse:**
  - `start` asserted mid-sweep at phase 5: restarts from phase 0 with `phase_flag` cleared;
  - `rst` pulsed mid-EVAL: all outputs 0 the next cycle.
